// File: rtl/fifo_burst_reader.sv
// Burst read engine: pops exactly len words from a show-ahead FIFO and streams them out
// through a 2-entry registered buffer. Optional handshake counter: FIFO_BURST_READER_COUNT_EN.
module fifo_burst_reader #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_BURST_READER_COUNT_EN
    ,
    output logic [LEN_W-1:0] xfer_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] to_fetch;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic [WIDTH-1:0] tail;
    logic             hs;

    assign hs = m_valid && m_ready;

    // Pop depends only on registered state and fifo_empty, keeping m_ready off this path.
    assign fifo_pop = (state == FETCH) && !fifo_empty && (occ != 2'd2) && (to_fetch != '0);

    always_comb begin
        occ_nxt = occ;
        if (fifo_pop && !hs)
            occ_nxt = occ + 2'd1;
        else if (!fifo_pop && hs)
            occ_nxt = occ - 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            occ      <= 2'd0;
            to_fetch <= '0;
        end else begin
            occ     <= occ_nxt;
            m_valid <= (occ_nxt != 2'd0);
            if (hs && occ == 2'd2)
                m_data <= tail;
            else if (fifo_pop && (occ == 2'd0 || hs))
                m_data <= fifo_data;
            if (fifo_pop)
                to_fetch <= to_fetch - LEN_W'(1);

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        to_fetch <= len;
                        busy     <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fifo_pop && to_fetch == LEN_W'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (occ_nxt == 2'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Abort discards buffered words and any remaining fetch count.
            if (abort && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b0;
                occ      <= 2'd0;
                m_valid  <= 1'b0;
                to_fetch <= '0;
            end
        end
    end

    // Second buffer slot is only read when occ==2, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fifo_pop && occ == 2'd1 && !hs)
            tail <= fifo_data;
    end

`ifdef FIFO_BURST_READER_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            xfer_cnt <= '0;
        else if (state == IDLE && start && !abort)
            xfer_cnt <= '0;
        else if (hs)
            xfer_cnt <= xfer_cnt + LEN_W'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: directed bursts against a small FIFO model.
module tb_fifo_burst_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_pop;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
`ifdef FIFO_BURST_READER_COUNT_EN
    logic [7:0]  xfer_cnt;
`endif

    fifo_burst_reader #(.WIDTH(16), .LEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_BURST_READER_COUNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [15:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr % 64];
    always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, predicting the next rising edge
    int   hs_total  = 0;
    int   pop_total = 0;
    int   streak    = 0;
    int   occ_m     = 0;
    bit   prev_hs   = 0;
    bit   prev_hold = 0;
    bit   prev_abort = 0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        logic [15:0] w;
        if (prev_hold && !prev_abort && reset_n) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
        end
        if (fifo_pop) begin
            check("pop_nonempty", fifo_empty, 0);
            check("pop_occ_lt2", (occ_m < 2), 1);
            pop_total++;
        end
        if (done && reset_n)
            check("done_after_all_words", exp_q.size(), 0);
        if (m_valid && m_ready && reset_n) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h required none", m_data);
            end else begin
                w = exp_q.pop_front();
                check("m_data", m_data, w);
            end
            hs_total++;
            streak = prev_hs ? streak + 1 : 1;
        end
        occ_m = occ_m + (fifo_pop ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        if (!reset_n || (abort && busy)) occ_m = 0;
        prev_hs    = m_valid && m_ready && reset_n;
        prev_hold  = m_valid && !m_ready;
        prev_data  = m_data;
        prev_abort = abort;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    logic [3:0] bp_pat = 4'b1001;

    // Waits for done; c0 is the number of edges already elapsed since the start edge.
    task automatic wait_done(input int c0, input int maxc, input bit bp, output int n);
        int i;
        i = c0;
        while (!done && i < maxc) begin
            if (bp) m_ready = bp_pat[i % 4];
            tick();
            i++;
        end
        check("done_seen", done, 1);
        n = i;
    endtask

    task automatic issue(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int hs0;
        int pop0;
        reset_n = 1'b0;
        start   = 1'b0;
        len     = '0;
        abort   = 1'b0;
        m_ready = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Basic burst: 8 alternating words, consumer always ready
        for (int k = 0; k < 8; k++) begin
            push(k[0] ? 16'h0000 : 16'hFFFF);
            exp_q.push_back(k[0] ? 16'h0000 : 16'hFFFF);
        end
        m_ready = 1'b1;
        hs0 = hs_total;
        issue(8'd8);
        check("basic_busy", busy, 1);
        check("basic_first_pop", fifo_pop, 1);
        check("basic_valid_e1", m_valid, 0);
        tick();
        check("basic_valid_e2", m_valid, 1);
        check("basic_first_data", m_data, 16'hFFFF);
        wait_done(2, 40, 0, n);
        check("basic_done_edge", n, 10);
        check("basic_hs_count", hs_total - hs0, 8);
        check("basic_consecutive", streak, 8);
        check("basic_fifo_empty", fifo_empty, 1);
        tick();
        check("basic_done_pulse", done, 0);
        check("basic_idle", busy, 0);

        // Back-pressure: ready pattern 1,0,0,1
        push(16'h1234); push(16'hEDCB); push(16'h1234); push(16'hEDCB);
        exp_q.push_back(16'h1234); exp_q.push_back(16'hEDCB);
        exp_q.push_back(16'h1234); exp_q.push_back(16'hEDCB);
        hs0 = hs_total;
        issue(8'd4);
        wait_done(1, 60, 1, n);
        check("bp_hs_count", hs_total - hs0, 4);
        m_ready = 1'b1;
        tick();

        // Underflow stall: 1 word present, 2 more arrive 10 cycles later
        push(16'hA001);
        exp_q.push_back(16'hA001); exp_q.push_back(16'hA002); exp_q.push_back(16'hA003);
        hs0 = hs_total;
        issue(8'd3);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_no_done", done, 0);
        end
        check("stall_busy", busy, 1);
        check("stall_one_word", hs_total - hs0, 1);
        push(16'hA002); push(16'hA003);
        wait_done(1, 40, 0, n);
        check("stall_hs_count", hs_total - hs0, 3);
        tick();

        // Zero length
        pop0 = pop_total;
        issue(8'd0);
        check("zero_done", done, 1);
        check("zero_valid", m_valid, 0);
        tick();
        check("zero_done_pulse", done, 0);
        check("zero_idle", busy, 0);
        check("zero_no_pop", pop_total - pop0, 0);

        // Abort with two words buffered and consumer stalled
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push(16'h1111 * k[15:0]);
        hs0  = hs_total;
        pop0 = pop_total;
        issue(8'd6);
        tick();
        tick();
        check("abort_pre_valid", m_valid, 1);
        check("abort_pre_data", m_data, 16'h1111);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_idle", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_pops", pop_total - pop0, 2);
        tick();
        check("abort_no_done2", done, 0);
        check("abort_no_hs", hs_total - hs0, 0);
        for (int k = 3; k <= 6; k++) exp_q.push_back(16'h1111 * k[15:0]);
        m_ready = 1'b1;
        issue(8'd4);
        check("abort_restart_busy", busy, 1);
        wait_done(1, 40, 0, n);
        check("abort_restart_hs", hs_total - hs0, 4);
        tick();

        // Reset mid-burst
        m_ready = 1'b0;
        push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
        issue(8'd4);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_pop", fifo_pop, 0);
        check("mrst_valid", m_valid, 0);
        check("mrst_data", m_data, 0);
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.push_back(16'hB003); exp_q.push_back(16'hB004);
        m_ready = 1'b1;
        hs0 = hs_total;
        issue(8'd2);
        wait_done(1, 40, 0, n);
        check("mrst_after_hs", hs_total - hs0, 2);
        tick();

`ifdef FIFO_BURST_READER_COUNT_EN
        for (int k = 1; k <= 5; k++) begin
            push(16'hC000 + k[15:0]);
            exp_q.push_back(16'hC000 + k[15:0]);
        end
        issue(8'd5);
        wait_done(1, 40, 0, n);
        check("cnt_at_done", xfer_cnt, 5);
        tick();
        check("cnt_held", xfer_cnt, 5);
        issue(8'd0);
        check("cnt_cleared", xfer_cnt, 0);
        tick();
`endif

        check("final_exp_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
